// File: rtl/bus_rr_arbiter_pkg.sv
// bus_rr_arbiter_pkg: shared state encoding, master indices and sizing constants
package bus_rr_arbiter_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } arb_state_t;
    localparam int NUM_MASTERS_MAX = 8;
    localparam int BUS_ICACHE      = 0;
    localparam int BUS_DCACHE      = 1;
    localparam int BUS_DMA         = 2;
    localparam int WDOG_W          = 16;
endpackage

// File: rtl/bus_rr_pick.sv
// bus_rr_pick: rotate-priority encoder, first eligible master after i_last with wrap
module bus_rr_pick
    import bus_rr_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 8
) (
    input  logic [NUM_MASTERS-1:0] i_eligible,
    input  logic [2:0]             i_last,
    output logic [2:0]             o_winner,
    output logic                   o_valid
);
    logic [NUM_MASTERS_MAX-1:0] w_elig;
    logic [2:0]                 w_idx;

    assign w_elig = NUM_MASTERS_MAX'(i_eligible);

    // Scan from farthest to nearest so the nearest eligible master is written last.
    always_comb begin
        o_winner = '0;
        o_valid  = 1'b0;
        w_idx    = '0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            w_idx = 3'((int'(i_last) + k) % NUM_MASTERS);
            if (w_elig[w_idx]) begin
                o_winner = w_idx;
                o_valid  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: round-robin bus arbiter with registered one-hot grant,
// one-cycle turnaround between owners and a watchdog that revokes stuck grants.
module bus_rr_arbiter
    import bus_rr_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS    = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] bus_req,
    input  logic                   bus_ready,
    output logic [NUM_MASTERS-1:0] bus_ack,
    output logic [2:0]             grant_id,
    output logic                   bus_busy,
    output logic                   timeout
);
    localparam logic [WDOG_W-1:0]      WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_MASTERS-1:0] ONE       = NUM_MASTERS'(1);

    arb_state_t                 r_state, w_state_n;
    logic [NUM_MASTERS-1:0]     r_ack, w_ack_n, r_mask, w_mask_n, w_elig, w_owner_oh;
    logic [2:0]                 r_id, w_id_n, r_last, w_last_n, w_win;
    logic [WDOG_W-1:0]          r_wdog, w_wdog_n;
    logic                       r_timeout, w_timeout_n, w_win_vld, w_owner_req;
    logic [NUM_MASTERS_MAX-1:0] w_req8;

    assign w_req8      = NUM_MASTERS_MAX'(bus_req);
    assign w_owner_req = w_req8[r_id];
    assign w_owner_oh  = ONE << r_id;
    assign w_elig      = bus_req & ~r_mask;

    bus_rr_pick #(.NUM_MASTERS(NUM_MASTERS)) u_pick (
        .i_eligible (w_elig),
        .i_last     (r_last),
        .o_winner   (w_win),
        .o_valid    (w_win_vld)
    );

    // A mask bit survives only while its master keeps requesting.
    always_comb begin
        w_state_n   = r_state;
        w_ack_n     = r_ack;
        w_id_n      = r_id;
        w_last_n    = r_last;
        w_wdog_n    = r_wdog;
        w_timeout_n = 1'b0;
        w_mask_n    = r_mask & bus_req;
        case (r_state)
            ST_IDLE: if (w_win_vld) begin
                w_ack_n   = ONE << w_win;
                w_id_n    = w_win;
                w_last_n  = w_win;
                w_wdog_n  = '0;
                w_state_n = ST_GRANT;
            end
            ST_GRANT: if (!w_owner_req) begin
                w_ack_n   = '0;
                w_state_n = ST_TURN;
            end else if (bus_ready) begin
                w_wdog_n = '0;
            end else if (TIMEOUT_CYCLES != 0 && r_wdog == WDOG_LAST) begin
                w_ack_n     = '0;
                w_timeout_n = 1'b1;
                w_mask_n    = w_mask_n | w_owner_oh;
                w_state_n   = ST_TURN;
            end else begin
                w_wdog_n = (r_wdog == '1) ? r_wdog : r_wdog + 1'b1;
            end
            default: begin
                w_ack_n   = '0;
                w_state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ack     <= '0;
            r_id      <= '0;
            r_last    <= 3'(NUM_MASTERS - 1);
            r_mask    <= '0;
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_ack     <= w_ack_n;
            r_id      <= w_id_n;
            r_last    <= w_last_n;
            r_mask    <= w_mask_n;
            r_wdog    <= w_wdog_n;
            r_timeout <= w_timeout_n;
        end
    end

    assign bus_ack  = r_ack;
    assign grant_id = r_id;
    assign bus_busy = |r_ack;
    assign timeout  = r_timeout;
endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb_bus_rr_arbiter: directed scoreboard bench for bus_rr_arbiter (8 masters, 4-cycle watchdog)
module tb_bus_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] bus_req;
    logic       bus_ready;
    logic [7:0] bus_ack;
    logic [2:0] grant_id;
    logic       bus_busy;
    logic       timeout;

    int n_chk  = 0;
    int n_fail = 0;
    int sb[$];

    bus_rr_arbiter #(.NUM_MASTERS(8), .TIMEOUT_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_req   (bus_req),
        .bus_ready (bus_ready),
        .bus_ack   (bus_ack),
        .grant_id  (grant_id),
        .bus_busy  (bus_busy),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for a non-zero ack; dead = number of ack-low cycles seen first.
    task automatic wait_grant(output int dead);
        dead = 0;
        @(negedge clk);
        while (bus_ack == 8'h00 && dead < 20) begin
            dead++;
            @(negedge clk);
        end
    endtask

    task automatic check_grant(input string tag);
        int e;
        e = sb.pop_front();
        chk({tag, "_ack"}, 32'(bus_ack), 32'(8'h01 << e));
        chk({tag, "_id"}, 32'(grant_id), 32'(e));
        chk({tag, "_busy"}, 32'(bus_busy), 32'd1);
    endtask

    initial begin
        int dead, hi, own;
        rst = 1'b1; bus_req = 8'h00; bus_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ack", 32'(bus_ack), 32'h0);
        chk("rst_id", 32'(grant_id), 32'h0);
        chk("rst_busy", 32'(bus_busy), 32'h0);
        chk("rst_to", 32'(timeout), 32'h0);

        // Single requester: one-cycle latency, then TURN
        rst = 1'b0; bus_req = 8'h01; bus_ready = 1'b1;
        sb.push_back(0);
        wait_grant(dead);
        chk("t1_lat", 32'(dead), 32'd0);
        check_grant("t1");
        bus_req = 8'h00;
        @(negedge clk);
        chk("t1_rel_ack", 32'(bus_ack), 32'h0);
        chk("t1_rel_busy", 32'(bus_busy), 32'h0);
        @(negedge clk);
        chk("t1_idle_id", 32'(grant_id), 32'h0);

        // Everyone requesting: strict rotation with two dead cycles per handoff
        bus_req = 8'hFF;
        for (int i = 0; i < 8; i++) sb.push_back((i + 1) % 8);
        wait_grant(dead);
        chk("t2_first_lat", 32'(dead), 32'd0);
        for (int i = 0; i < 8; i++) begin
            own = (i + 1) % 8;
            check_grant($sformatf("t2_g%0d", i));
            @(negedge clk);
            chk($sformatf("t2_hold%0d", i), 32'(bus_ack), 32'(8'h01 << own));
            bus_req[own] = 1'b0;
            @(negedge clk);
            chk($sformatf("t2_drop%0d", i), 32'(bus_ack), 32'h0);
            bus_req[own] = 1'b1;
            if (i < 7) begin
                wait_grant(dead);
                chk($sformatf("t2_dead%0d", i), 32'(dead + 1), 32'd2);
            end
        end
        bus_req = 8'h00;
        repeat (2) @(negedge clk);

        // Owner 3 releases while 1 and 5 wait: 5 follows, then 1
        bus_req = 8'h08;
        sb.push_back(3);
        wait_grant(dead);
        check_grant("t3_own3");
        bus_req = 8'h2A;
        repeat (2) @(negedge clk);
        chk("t3_hold3", 32'(bus_ack), 32'h08);
        bus_req = 8'h22;
        sb.push_back(5);
        wait_grant(dead);
        chk("t3_dead5", 32'(dead), 32'd2);
        check_grant("t3_g5");
        bus_req = 8'h02;
        sb.push_back(1);
        wait_grant(dead);
        check_grant("t3_g1");
        bus_req = 8'h00;
        @(negedge clk);
        chk("t3_rel_ack", 32'(bus_ack), 32'h0);
        chk("t3_hold_id", 32'(grant_id), 32'h1);
        @(negedge clk);

        // Watchdog: master 2 stuck with no bus_ready
        bus_ready = 1'b0; bus_req = 8'h04;
        sb.push_back(2);
        wait_grant(dead);
        check_grant("t4_g2");
        hi = 1;
        while (bus_ack != 8'h00 && hi < 20) begin
            @(negedge clk);
            if (bus_ack != 8'h00) hi++;
        end
        chk("t4_ack_cycles", 32'(hi), 32'd4);
        chk("t4_to_pulse", 32'(timeout), 32'd1);
        bus_req = 8'h44;
        @(negedge clk);
        chk("t4_to_width", 32'(timeout), 32'd0);
        sb.push_back(6);
        wait_grant(dead);
        check_grant("t4_g6");
        bus_ready = 1'b1;
        bus_req = 8'h04;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("t4_masked%0d", i), 32'(bus_ack), 32'h0);
        end
        bus_req = 8'h00;
        @(negedge clk);
        bus_req = 8'h04;
        sb.push_back(2);
        wait_grant(dead);
        check_grant("t4_regrant2");
        bus_req = 8'h00;
        repeat (2) @(negedge clk);

        // bus_ready every third cycle keeps a long grant alive
        bus_ready = 1'b0; bus_req = 8'h10;
        sb.push_back(4);
        wait_grant(dead);
        check_grant("t5_g4");
        for (int c = 0; c < 20; c++) begin
            bus_ready = (c % 3 == 2);
            @(negedge clk);
            chk($sformatf("t5_ack%0d", c), 32'(bus_ack), 32'h10);
            chk($sformatf("t5_to%0d", c), 32'(timeout), 32'h0);
        end
        bus_ready = 1'b1; bus_req = 8'h00;
        repeat (2) @(negedge clk);

        // Reset in the second cycle of a grant, then priority restarts at master 0
        bus_req = 8'h08;
        sb.push_back(3);
        wait_grant(dead);
        check_grant("t6_g3");
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_ack", 32'(bus_ack), 32'h0);
        chk("t6_rst_to", 32'(timeout), 32'h0);
        chk("t6_rst_id", 32'(grant_id), 32'h0);
        rst = 1'b0; bus_req = 8'h11;
        sb.push_back(0);
        wait_grant(dead);
        check_grant("t6_g0");
        chk("t6_sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bus_rr_arbiter.md
Name: bus_rr_arbiter

Overview:
- Round-robin arbiter for the shared system bus (address, read/write data, rd/wr strobes, ready) used by up to 8 masters: icache first, later dcache and DMA.
- Takes one request line per master and drives a one-hot, registered grant.
- A grant is held for the owner's whole transaction.
- Adds a turnaround gap between owners and a watchdog that revokes a stuck grant.
- Replaces the combinational BusArbiter; bus muxing stays outside this block, keyed on grant_id.

Parameters:
- NUM_MASTERS, 8, number of request/ack lines; legal range 2..8.
- TIMEOUT_CYCLES, 1024, grant cycles allowed with no bus_ready before forced release; 0 disables the watchdog; max 65535.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  synchronous active-high reset.
- bus_req  in  NUM_MASTERS  per-master request; level, held for the whole transaction.
- bus_ready  in  1  slave completion strobe for the current beat; restarts the watchdog.
- bus_ack  out  NUM_MASTERS  one-hot grant, registered; all-zero when nobody owns the bus.
- grant_id  out  3  index of the current owner; holds the last owner when bus_ack is 0.
- bus_busy  out  1  high whenever bus_ack is non-zero.
- timeout  out  1  one-cycle pulse when the watchdog revokes a grant.

Behaviour:
- Reset values: bus_ack=0, grant_id=0, bus_busy=0, timeout=0, state=IDLE, last=NUM_MASTERS-1, mask=0, wdog=0. On the first arbitration after reset, master 0 has top priority.
- Reset mid-grant: rst overrides everything; bus_ack reads 0 from the cycle after the reset edge.
- States: IDLE, GRANT, TURN; 2-bit encoding from the shared package.
- IDLE: eligible = bus_req & ~mask.
  - If eligible is non-zero, winner = first set bit scanning last+1, last+2, ... with wrap modulo NUM_MASTERS.
  - At the clock edge: bus_ack<=onehot(winner), grant_id<=winner, last<=winner, wdog<=0, state<=GRANT.
  - Latency: request sampled at edge k gives ack visible in cycle k+1.
- GRANT:
  - If bus_req[grant_id]==0 at an edge: bus_ack<=0, state<=TURN.
  - Otherwise, if bus_ready is high: wdog<=0.
  - Otherwise, if TIMEOUT_CYCLES!=0 and wdog==TIMEOUT_CYCLES-1: bus_ack<=0, timeout<=1 for one cycle, mask[grant_id]<=1, state<=TURN.
  - Otherwise: wdog<=wdog+1, saturating and 16 bits wide.
  - A request drop on the same edge as the watchdog expiring counts as a normal release: no timeout pulse, no mask set.
- TURN: exactly one cycle with bus_ack=0, then state<=IDLE. No arbitration happens in TURN.
  - Handoff: owner drops req before edge m, then ack is low in cycles m+1 and m+2, and the new ack appears in cycle m+3.
- mask:
  - A bit clears on any edge where the matching bus_req bit is 0.
  - A timed-out master is not re-granted until it deasserts its request for at least one cycle.
  - Other masters are unaffected.
- Requests from a non-owner in GRANT or TURN are ignored, not latched; requesters must hold bus_req.
- Single requester held continuously with no timeout: stays granted indefinitely.
- After a release, the same master re-requesting with no competitors is re-granted after the TURN cycle.
- Fairness: with all NUM_MASTERS requesting, each master is granted exactly once per NUM_MASTERS grants.
- bus_busy = |bus_ack, driven from the registered ack (no extra delay).
- Request bits above NUM_MASTERS-1 do not exist; grant_id upper bits are 0 when NUM_MASTERS<8.

Decomposition:
- Shared package:
  - state enum (IDLE/GRANT/TURN);
  - NUM_MASTERS_MAX=8;
  - bus master index constants BUS_ICACHE=0, BUS_DCACHE=1, BUS_DMA=2;
  - watchdog width constant WDOG_W=16.
- One sub-module, bus_rr_pick: combinational rotate-priority encoder. Inputs are eligible vector and last; outputs are winner index and a valid flag.
- FSM, mask, watchdog and output registers stay in bus_rr_arbiter.

Test Plan:
- Reset, then bus_req=8'b0000_0001 asserted before edge 1 -> bus_ack=8'h01, grant_id=0, bus_busy=1 in cycle 2; drop req -> ack 0 next cycle, TURN, IDLE.
- bus_req=8'hFF held, each owner dropping its req after 2 cycles then re-raising -> grant order 0,1,2,...,7,0; exactly two dead cycles between acks.
- Owner 3 granted, masters 1 and 5 requesting, 3 releases -> next grant is 5, then 1.
- TIMEOUT_CYCLES=4, master 2 holds req with no bus_ready -> ack high 4 cycles, then timeout pulse of width 1, ack 0. Master 2 is not regranted while req held; master 6 requesting is granted. Master 2 drops for 1 cycle, re-requests -> granted.
- TIMEOUT_CYCLES=4, bus_ready pulsed every 3 cycles during a 20-cycle grant -> no timeout, ack held all 20 cycles.
- rst asserted in the second cycle of a grant with req still high -> bus_ack=0, timeout=0 after the reset edge. After rst drops, master 0 wins over master 4 when both request.
